muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_if.sv | 37 +++
 rtl/muldiv_addsub.sv | 25 ++
 rtl/muldiv_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared constants for the multiply/divide sequencer:
//   - default operand width and iteration counter width
//   - op encodings presented on the request interface
//   - FSM state encoding, kept as plain constants for legacy tools
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MUL   = 3'd1;
  localparam logic [2:0] ST_DIV   = 3'd2;
  localparam logic [2:0] ST_FIXUP = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// Request/result bundle between the control unit and the mul/div sequencer.
//   start : operation request, sampled while busy is low
//   op    : 0 = signed multiply, 1 = signed divide
//   a, b  : multiplicand/multiplier or dividend/divisor
//   busy  : unit occupied, from the accepting edge until done drops
//   done  : one-cycle pulse, hi/lo valid from this cycle
//   hi,lo : product halves, or remainder/quotient
//   div0  : divide-by-zero flag (zero unless the detect option is built in)
// Modports: master = requester (control unit), slave = sequencer.
// -----------------------------------------------------------------------------
interface muldiv_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div0;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div0
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div0
  );

endinterface

// File: rtl/muldiv_addsub.sv
// -----------------------------------------------------------------------------
// muldiv_addsub
// Combinational (WIDTH+1)-bit adder/subtractor shared by the Booth multiply
// and the non-restoring divide iterations.
//   i_a   : first operand
//   i_b   : second operand
//   i_sub : 1 = i_a - i_b, 0 = i_a + i_b
//   o_sum : result, wraps modulo 2^(WIDTH+1)
// -----------------------------------------------------------------------------
module muldiv_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] i_a,
  input  logic [WIDTH:0] i_b,
  input  logic           i_sub,
  output logic [WIDTH:0] o_sum
);

  logic [WIDTH:0] w_bx;

  // Subtraction as a + ~b + 1 so a single carry chain serves both directions.
  assign w_bx  = i_b ^ {(WIDTH+1){i_sub}};
  assign o_sum = i_a + w_bx + {{WIDTH{1'b0}}, i_sub};

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Multi-cycle signed multiply/divide unit driving the HI/LO register pair.
//   MUL: radix-2 Booth, one bit per cycle, WIDTH iterations, done after
//        WIDTH+1 edges counting the accepting edge.
//   DIV: non-restoring division on magnitudes, WIDTH iterations plus one
//        sign fix-up cycle, done after WIDTH+2 edges.
// Ports:
//   clk : rising-edge clock
//   clr : asynchronous active-high reset
//   bus : muldiv_if slave (start/op/a/b in, busy/done/hi/lo/div0 out)
// Parameters:
//   WIDTH : operand width, even and >= 4
//   CNT_W : iteration counter width, 2^CNT_W > WIDTH
// Build option:
//   MULDIV_DIV0_DETECT_EN : a DIV with b = 0 finishes on the accepting edge
//   with hi = a, lo = all-ones and div0 = 1 (held until the next accept).
//   Without it div0 is tied low and b = 0 runs the full divide sequence.
// -----------------------------------------------------------------------------
import muldiv_pkg::*;

module muldiv_sequencer #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic    clk,
  input  logic    clr,
  muldiv_if.slave bus
);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  // MUL: Booth accumulator A. DIV: partial remainder R (two's complement).
  logic [WIDTH:0]   r_acc;
  // MUL: sign-extended multiplicand. DIV: zero-extended |b|.
  logic [WIDTH:0]   r_m;
  // MUL: multiplier Q shifting right. DIV: |a| shifting out / quotient in.
  logic [WIDTH-1:0] r_q;
  logic             r_qm1;
  logic             r_negq;
  logic             r_negr;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH:0]   w_addA;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rShift;
  logic [WIDTH:0]   w_mulAcc;
  logic             w_sub;
  logic             w_accept;
  logic             w_isDiv;
  logic             w_div0Skip;
  logic             w_lastIter;
  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;
  logic [WIDTH-1:0] w_remMag;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_quo;

  assign w_isDiv  = (bus.op == OP_DIV);
  assign w_accept = (r_state == ST_IDLE) && bus.start;

  // |-2^(W-1)| = 2^(W-1) still fits as an unsigned W-bit magnitude.
  assign w_absA = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
  assign w_absB = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;

`ifdef MULDIV_DIV0_DETECT_EN
  assign w_div0Skip = w_isDiv && (bus.b == '0);
`else
  assign w_div0Skip = 1'b0;
`endif

  // {R, Q} shifted left one place; R stays within W+1 bits because
  // |R| < |b| <= 2^(W-1) throughout the divide.
  assign w_rShift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};

  // Operand/direction select for the shared adder. FIXUP uses the default
  // (R + |b|) to restore a negative final remainder.
  always_comb begin
    w_addA = r_acc;
    w_sub  = 1'b0;
    case (r_state)
      ST_MUL: w_sub = r_q[0] & ~r_qm1;
      ST_DIV: begin
        w_addA = w_rShift;
        w_sub  = ~r_acc[WIDTH];
      end
      default: ;
    endcase
  end

  muldiv_addsub #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .i_a   (w_addA),
    .i_b   (r_m),
    .i_sub (w_sub),
    .o_sum (w_sum)
  );

  // Booth pairs 00/11 leave A untouched; 01/10 take the adder result.
  assign w_mulAcc   = (r_q[0] ^ r_qm1) ? w_sum : r_acc;
  assign w_lastIter = (r_cnt == CNT_W'(WIDTH - 1));

  assign w_remMag = r_acc[WIDTH] ? w_sum[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem    = r_negr ? (~w_remMag + 1'b1) : w_remMag;
  assign w_quo    = r_negq ? (~r_q + 1'b1) : r_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_negq  <= 1'b0;
      r_negr  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
            if (w_div0Skip) begin
              r_hi    <= bus.a;
              r_lo    <= '1;
              r_state <= ST_DONE;
            end else if (w_isDiv) begin
              r_acc   <= '0;
              r_q     <= w_absA;
              r_m     <= {1'b0, w_absB};
              r_negq  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
              r_negr  <= bus.a[WIDTH-1];
              r_state <= ST_DIV;
            end else begin
              r_acc   <= '0;
              r_q     <= bus.b;
              r_qm1   <= 1'b0;
              r_m     <= {bus.a[WIDTH-1], bus.a};
              r_state <= ST_MUL;
            end
          end
        end

        ST_MUL: begin
          // Arithmetic right shift of {A, Q, q_-1}.
          r_acc <= {w_mulAcc[WIDTH], w_mulAcc[WIDTH:1]};
          r_q   <= {w_mulAcc[0], r_q[WIDTH-1:1]};
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt + 1'b1;
          if (w_lastIter) begin
            r_hi    <= w_mulAcc[WIDTH:1];
            r_lo    <= {w_mulAcc[0], r_q[WIDTH-1:1]};
            r_state <= ST_DONE;
          end
        end

        ST_DIV: begin
          r_acc <= w_sum;
          r_q   <= {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
          r_cnt <= r_cnt + 1'b1;
          if (w_lastIter) begin
            r_state <= ST_FIXUP;
          end
        end

        ST_FIXUP: begin
          r_hi    <= w_rem;
          r_lo    <= w_quo;
          r_state <= ST_DONE;
        end

        ST_DONE: r_state <= ST_IDLE;

        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef MULDIV_DIV0_DETECT_EN
  logic r_div0;

  // Set or cleared on every accept, so it survives until the next request.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_div0 <= 1'b0;
    end else if (w_accept) begin
      r_div0 <= w_div0Skip;
    end
  end

  assign bus.div0 = r_div0;
`else
  assign bus.div0 = 1'b0;
`endif

  assign bus.busy = (r_state != ST_IDLE);
  assign bus.done = (r_state == ST_DONE);
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Self-checking bench for muldiv_sequencer (WIDTH = 32). Results are compared
// against a reference computed with 64-bit signed arithmetic; latency is the
// number of clock edges from the accepting edge (counted as 1) to done.
// Build option MULDIV_DIV0_DETECT_EN selects the divide-by-zero scenario.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;

`ifdef MULDIV_DIV0_DETECT_EN
  localparam bit DIV0_EN = 1'b1;
`else
  localparam bit DIV0_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(
    .WIDTH(W),
    .CNT_W(6)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  int vectorCount = 0;
  int missCount   = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Reference result {hi, lo} from plain signed arithmetic.
  function automatic logic [63:0] refModel(input logic opIn, input logic [31:0] aIn,
                                           input logic [31:0] bIn);
    longint sa, sb, q, rm;
    logic [63:0] p;
    sa = longint'($signed(aIn));
    sb = longint'($signed(bIn));
    if (opIn == OP_MUL) begin
      p = sa * sb;
      return p;
    end
    if (sb == 0) return {aIn, 32'hFFFF_FFFF};
    q  = sa / sb;
    rm = sa % sb;
    return {rm[31:0], q[31:0]};
  endfunction

  function automatic int refLatency(input logic opIn, input logic [31:0] bIn);
    if (opIn == OP_MUL) return W + 1;
    if (DIV0_EN && bIn == 32'd0) return 1;
    return W + 2;
  endfunction

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 9))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Issues one request, then waits (bounded) for done. Inputs are scrambled
  // after the accepting edge since the unit must have latched them.
  task automatic applyStimulus(input logic opIn, input logic [31:0] aIn,
                               input logic [31:0] bIn, output int latency,
                               output int busyCycles);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = opIn;
    bus.a     = aIn;
    bus.b     = bIn;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.op     = 1'($urandom);
    bus.a      = $urandom;
    bus.b      = $urandom;
    latency    = 1;
    busyCycles = bus.busy ? 1 : 0;
    while (!bus.done && latency < 200) begin
      @(posedge clk);
      #1;
      latency++;
      if (bus.busy) busyCycles++;
    end
  endtask

  task automatic runAndCheck(input string tag, input logic opIn, input logic [31:0] aIn,
                             input logic [31:0] bIn);
    int lat, bc, expLat;
    logic resultDefined;
    applyStimulus(opIn, aIn, bIn, lat, bc);
    expLat        = refLatency(opIn, bIn);
    resultDefined = (opIn == OP_MUL) || (bIn != 32'd0) || DIV0_EN;
    checkOutput({tag, ".latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, ".busyCycles"}, 64'(bc), 64'(expLat));
    if (resultDefined)
      checkOutput({tag, ".hilo"}, {bus.hi, bus.lo}, refModel(opIn, aIn, bIn));
    checkOutput({tag, ".div0"}, 64'(bus.div0),
                64'(DIV0_EN && opIn == OP_DIV && bIn == 32'd0));
    @(posedge clk);
    #1;
    checkOutput({tag, ".doneDrop"}, {62'd0, bus.done, bus.busy}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int edgeCnt;
    logic doneSeen;
    logic [31:0] ra, rb;

    clr       = 1'b1;
    bus.start = 1'b0;
    bus.op    = OP_MUL;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.busy", 64'(bus.busy), 64'd0);
    checkOutput("reset.done", 64'(bus.done), 64'd0);
    checkOutput("reset.hilo", {bus.hi, bus.lo}, 64'd0);
    checkOutput("reset.div0", 64'(bus.div0), 64'd0);
    clr = 1'b0;

    // Directed cases with hand-computed results alongside the model.
    runAndCheck("mul7xm3", OP_MUL, 32'd7, 32'hFFFF_FFFD);
    checkOutput("mul7xm3.const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    runAndCheck("mulMinSq", OP_MUL, 32'h8000_0000, 32'h8000_0000);
    checkOutput("mulMinSq.const", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
    runAndCheck("mulM1Sq", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("mulM1Sq.const", {bus.hi, bus.lo}, 64'h0000_0000_0000_0001);
    runAndCheck("divM7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    checkOutput("divM7by2.const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    runAndCheck("divOvf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("divOvf.const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

`ifdef MULDIV_DIV0_DETECT_EN
    runAndCheck("div0", OP_DIV, 32'd5, 32'd0);
    checkOutput("div0.const", {bus.hi, bus.lo}, 64'h0000_0005_FFFF_FFFF);
    checkOutput("div0.hold", 64'(bus.div0), 64'd1);
    runAndCheck("div0Clear", OP_MUL, 32'd3, 32'd4);
`else
    runAndCheck("div0Off", OP_DIV, 32'd5, 32'd0);
`endif

    // A start pulse during a multiply must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.a     = 32'h1234_5678;
    bus.b     = 32'hFFFF_FF9C;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    edgeCnt   = 1;
    while (!bus.done && edgeCnt < 200) begin
      bus.start = (edgeCnt == 4);
      bus.op    = OP_DIV;
      bus.a     = $urandom;
      bus.b     = 32'd3;
      @(posedge clk);
      #1;
      edgeCnt++;
    end
    bus.start = 1'b0;
    checkOutput("ignoredStart.latency", 64'(edgeCnt), 64'(W + 1));
    checkOutput("ignoredStart.hilo", {bus.hi, bus.lo},
                refModel(OP_MUL, 32'h1234_5678, 32'hFFFF_FF9C));
    @(posedge clk);
    #1;

    // Abort mid-multiply with clr, then restart on the following edge.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.a     = 32'h0BAD_F00D;
    bus.b     = 32'h0000_0123;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    edgeCnt   = 1;
    doneSeen  = 1'b0;
    while (edgeCnt < 9) begin
      @(posedge clk);
      #1;
      edgeCnt++;
      if (bus.done) doneSeen = 1'b1;
    end
    #2;
    clr = 1'b1;
    #1;
    checkOutput("abort.busy", 64'(bus.busy), 64'd0);
    checkOutput("abort.done", 64'(bus.done), 64'd0);
    checkOutput("abort.hilo", {bus.hi, bus.lo}, 64'd0);
    checkOutput("abort.noEarlyDone", 64'(doneSeen), 64'd0);
    clr = 1'b0;
    runAndCheck("afterAbort", OP_MUL, 32'hFFFF_FF00, 32'd77);

    // Randomized operations against the reference model.
    for (int i = 0; i < 200; i++) begin
      ra = randOperand();
      rb = randOperand();
      runAndCheck("randMul", OP_MUL, ra, rb);
    end
    for (int i = 0; i < 200; i++) begin
      ra = randOperand();
      rb = randOperand();
      while (rb == 32'd0) rb = $urandom;
      runAndCheck("randDiv", OP_DIV, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
